// File: rtl/clock_pkg.sv
// Shared widths, moduli and mode decode for the time-of-day clock.
package clock_pkg;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_SEC  = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_HOUR = 2'd3
  } mode_e;

  // Hours win over minutes, minutes over seconds.
  function automatic mode_e decode_mode(input logic ms, input logic mm, input logic mh);
    if (mh)      return MODE_HOUR;
    else if (mm) return MODE_MIN;
    else if (ms) return MODE_SEC;
    else         return MODE_RUN;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter; wrap flags the enabled edge that rolls back to zero.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = en && (count == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     count <= '0;
    else if (en) count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/time_keeper.sv
// Hours:minutes:seconds clock with a one-second prescaler and pushbutton set modes.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_DIV   = 100000000,
  parameter int HOURS_MOD = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ms,
  input  logic              mm,
  input  logic              mh,
  input  logic              inc,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              set_active
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  mode_e         mode;
  logic [PW-1:0] presc;
  logic          tick;
  logic          inc_s1, inc_s2, inc_s3;
  logic          inc_p;
  logic          sec_en, min_en, hour_en;
  logic          sec_wrap, min_wrap, day_wrap_unused;

  assign set_active = ms | mm | mh;
  assign tick       = !set_active && (presc == PRESC_LAST);
  assign inc_p      = inc_s2 & ~inc_s3;

  always_comb begin
    mode    = decode_mode(ms, mm, mh);
    sec_en  = tick;
    min_en  = tick && sec_wrap;
    hour_en = tick && min_wrap;
    if (inc_p) begin
      case (mode)
        MODE_SEC:  sec_en  = 1'b1;
        MODE_MIN:  min_en  = 1'b1;
        MODE_HOUR: hour_en = 1'b1;
        default:   ;
      endcase
    end
  end

  // Prescaler parks at zero in set mode so RUN restarts with a full interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             presc <= '0;
    else if (set_active) presc <= '0;
    else if (tick)       presc <= '0;
    else                 presc <= presc + 1'b1;
  end

  // Two-flop synchronizer plus one history flop for the rising-edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_s1 <= 1'b0;
      inc_s2 <= 1'b0;
      inc_s3 <= 1'b0;
    end else begin
      inc_s1 <= inc;
      inc_s2 <= inc_s1;
      inc_s3 <= inc_s2;
    end
  end

  mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .en(sec_en), .count(sec), .wrap(sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk(clk), .rst(rst), .en(min_en), .count(min), .wrap(min_wrap)
  );

  mod_counter #(.MOD(HOURS_MOD), .W(HOUR_W)) u_hour (
    .clk(clk), .rst(rst), .en(hour_en), .count(hour), .wrap(day_wrap_unused)
  );

endmodule
